// File: rtl/dest_id_matcher.sv
// -----------------------------------------------------------------------------
// dest_id_matcher
//
// Decides whether a received packet is addressed to this node. A packet is
// accepted when its destination ID equals the node's own ID, the broadcast ID
// (optional), or any valid entry of a small programmable alias (group) table.
// The result is produced under an en/start/done handshake.
//
// Build option:
//   DEST_BROADCAST_EN  - when defined, a destination equal to BROADCAST_ID is
//                        accepted with matchType 11. When undefined there is
//                        no broadcast comparator; BROADCAST_ID is an ordinary
//                        ID and matchType never reads 11.
//
// Ports:
//   clock          system clock, rising edge
//   rst            synchronous active-high reset
//   en             block enable; low aborts any operation and ignores start
//   start          launch one match (accepted in IDLE or DONE)
//   MY_NODE_ID     node's own ID, latched at start
//   destinationID  packet destination, latched at start
//   tbl_we         alias table write strobe (dropped while busy)
//   tbl_addr       alias entry index (writes beyond NUM_ALIAS-1 ignored)
//   tbl_data       alias ID to store
//   tbl_valid      valid bit stored with the entry; 0 deletes the entry
//   iamDestination packet accepted (qualified by done)
//   matchType      00 none, 01 self, 10 alias, 11 broadcast
//   matchIndex     alias index hit; 0 unless matchType is 10
//   busy           high while CHECK or SCAN is in progress
//   done           result valid; held until next start, en low or rst
// -----------------------------------------------------------------------------
module dest_id_matcher #(
   parameter int                    WORD_WIDTH   = 16,
   parameter int                    NUM_ALIAS    = 4,
   parameter int                    IDX_WIDTH    = 2,
   parameter logic [WORD_WIDTH-1:0] BROADCAST_ID = 16'hFFFF
) (
   input  logic                  clock,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  start,
   input  logic [WORD_WIDTH-1:0] MY_NODE_ID,
   input  logic [WORD_WIDTH-1:0] destinationID,
   input  logic                  tbl_we,
   input  logic [IDX_WIDTH-1:0]  tbl_addr,
   input  logic [WORD_WIDTH-1:0] tbl_data,
   input  logic                  tbl_valid,
   output logic                  iamDestination,
   output logic [1:0]            matchType,
   output logic [IDX_WIDTH-1:0]  matchIndex,
   output logic                  busy,
   output logic                  done
);

   // The table storage is sized to the full index space so that any
   // tbl_addr value is a legal array index; entries at or above NUM_ALIAS
   // are never written and never scanned.
   localparam int DEPTH = 1 << IDX_WIDTH;

   localparam logic [1:0] MT_NONE  = 2'b00;
   localparam logic [1:0] MT_SELF  = 2'b01;
   localparam logic [1:0] MT_ALIAS = 2'b10;
`ifdef DEST_BROADCAST_EN
   localparam logic [1:0] MT_BCAST = 2'b11;
`endif

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CHECK,
      ST_SCAN,
      ST_DONE
   } state_t;

   state_t                  state_reg,  state_next;
   logic [WORD_WIDTH-1:0]   my_id_reg,  my_id_next;
   logic [WORD_WIDTH-1:0]   dest_reg,   dest_next;
   logic [IDX_WIDTH-1:0]    idx_reg,    idx_next;
   logic [1:0]              type_reg,   type_next;
   logic [IDX_WIDTH-1:0]    index_reg,  index_next;

   // Alias table: data in an inferred RAM with registered read, valid bits
   // in flops so that reset can clear them in one cycle.
   logic [WORD_WIDTH-1:0]   alias_mem [DEPTH];
   logic [WORD_WIDTH-1:0]   alias_rd_reg;
   logic [DEPTH-1:0]        valid_reg;
   logic [DEPTH-1:0]        valid_next;

   logic                    wr_en;
   logic                    is_last;
   logic                    alias_hit;

   // -------------------------------------------------------------------------
   // Status outputs derived from the state register
   // -------------------------------------------------------------------------
   assign busy           = (state_reg == ST_CHECK) || (state_reg == ST_SCAN);
   assign done           = (state_reg == ST_DONE);
   assign iamDestination = done && (type_reg != MT_NONE);
   assign matchType      = type_reg;
   assign matchIndex     = index_reg;

   // Table writes are only honoured while no match is in flight, so a scan
   // always sees a stable table. A write on the launch edge still commits
   // because the FSM is not yet busy on that edge.
   assign wr_en = tbl_we && !busy && (int'(tbl_addr) < NUM_ALIAS);

   // -------------------------------------------------------------------------
   // Valid bits: one next-value mux per entry
   // -------------------------------------------------------------------------
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
      assign valid_next[gi] = (wr_en && (tbl_addr == IDX_WIDTH'(gi))) ? tbl_valid
                                                                      : valid_reg[gi];
   end

   always_ff @(posedge clock) begin
      if (rst) begin
         valid_reg <= '0;
      end else begin
         valid_reg <= valid_next;
      end
   end

   // -------------------------------------------------------------------------
   // Alias data RAM. The read address is idx_next, so the entry that SCAN
   // examines in a given cycle was fetched on the previous edge: entering
   // SCAN from CHECK prefetches entry 0, and each increment prefetches the
   // following entry.
   // -------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (wr_en) begin
         alias_mem[tbl_addr] <= tbl_data;
      end
      alias_rd_reg <= alias_mem[idx_next];
   end

   assign is_last   = (int'(idx_reg) == NUM_ALIAS - 1);
   assign alias_hit = valid_reg[idx_reg] && (alias_rd_reg == dest_reg);

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (rst) begin
         state_reg <= ST_IDLE;
         my_id_reg <= '0;
         dest_reg  <= '0;
         idx_reg   <= '0;
         type_reg  <= MT_NONE;
         index_reg <= '0;
      end else begin
         state_reg <= state_next;
         my_id_reg <= my_id_next;
         dest_reg  <= dest_next;
         idx_reg   <= idx_next;
         type_reg  <= type_next;
         index_reg <= index_next;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      my_id_next = my_id_reg;
      dest_next  = dest_reg;
      idx_next   = idx_reg;
      type_next  = type_reg;
      index_next = index_reg;

      case (state_reg)
         ST_IDLE: begin
            if (en && start) begin
               my_id_next = MY_NODE_ID;
               dest_next  = destinationID;
               idx_next   = '0;
               type_next  = MT_NONE;
               index_next = '0;
               state_next = ST_CHECK;
            end
         end

         ST_CHECK: begin
            if (!en) begin
               // Abort: nothing of the partial result is kept.
               idx_next   = '0;
               type_next  = MT_NONE;
               index_next = '0;
               state_next = ST_IDLE;
            end else if (dest_reg == my_id_reg) begin
               type_next  = MT_SELF;
               state_next = ST_DONE;
            end
`ifdef DEST_BROADCAST_EN
            else if (dest_reg == BROADCAST_ID) begin
               type_next  = MT_BCAST;
               state_next = ST_DONE;
            end
`endif
            else begin
               idx_next   = '0;
               state_next = ST_SCAN;
            end
         end

         ST_SCAN: begin
            if (!en) begin
               idx_next   = '0;
               type_next  = MT_NONE;
               index_next = '0;
               state_next = ST_IDLE;
            end else if (alias_hit) begin
               // Scanning upward from 0 makes the lowest matching index win.
               type_next  = MT_ALIAS;
               index_next = idx_reg;
               state_next = ST_DONE;
            end else if (is_last) begin
               type_next  = MT_NONE;
               state_next = ST_DONE;
            end else begin
               idx_next = idx_reg + IDX_WIDTH'(1);
            end
         end

         ST_DONE: begin
            if (!en) begin
               idx_next   = '0;
               type_next  = MT_NONE;
               index_next = '0;
               state_next = ST_IDLE;
            end else if (start) begin
               // Back-to-back relaunch without passing through IDLE.
               my_id_next = MY_NODE_ID;
               dest_next  = destinationID;
               idx_next   = '0;
               type_next  = MT_NONE;
               index_next = '0;
               state_next = ST_CHECK;
            end
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

`ifndef DEST_BROADCAST_EN
   // Without the broadcast comparator the parameter has no function; this
   // keeps it referenced.
   logic unused_bcast;
   assign unused_bcast = ^BROADCAST_ID;
`endif

endmodule

// File: tb/tb_dest_id_matcher.sv
// -----------------------------------------------------------------------------
// tb_dest_id_matcher
//
// Directed bench for dest_id_matcher (WORD_WIDTH=16, NUM_ALIAS=4). A
// behavioural model predicts, per cycle, busy/done/iamDestination and the
// match result from the matching rules (priority self > broadcast > lowest
// valid alias, and the fixed latencies). Each directed transaction also
// checks hand-computed latency and result values.
// -----------------------------------------------------------------------------
module tb_dest_id_matcher;

   localparam int NA = 4;

`ifdef DEST_BROADCAST_EN
   localparam bit BC_EN = 1'b1;
`else
   localparam bit BC_EN = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic        start = 1'b0;
   logic [15:0] my_id = '0;
   logic [15:0] dest_id = '0;
   logic        tbl_we = 1'b0;
   logic [1:0]  tbl_addr = '0;
   logic [15:0] tbl_data = '0;
   logic        tbl_valid = 1'b0;

   logic        iam;
   logic [1:0]  mtype;
   logic [1:0]  midx;
   logic        busy;
   logic        done;

   int checks = 0;
   int failures = 0;

   dest_id_matcher #(
      .WORD_WIDTH  (16),
      .NUM_ALIAS   (NA),
      .IDX_WIDTH   (2),
      .BROADCAST_ID(16'hFFFF)
   ) dut (
      .clock         (clock),
      .rst           (rst),
      .en            (en),
      .start         (start),
      .MY_NODE_ID    (my_id),
      .destinationID (dest_id),
      .tbl_we        (tbl_we),
      .tbl_addr      (tbl_addr),
      .tbl_data      (tbl_data),
      .tbl_valid     (tbl_valid),
      .iamDestination(iam),
      .matchType     (mtype),
      .matchIndex    (midx),
      .busy          (busy),
      .done          (done)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Behavioural model
   // ---------------------------------------------------------------------------
   logic [15:0] m_alias [NA];
   logic        m_valid [NA];
   logic [15:0] v_alias [NA];
   logic        v_valid [NA];
   logic        live = 1'b0;
   logic        m_busy = 1'b0;
   logic        m_done = 1'b0;
   logic [1:0]  m_type = '0;
   logic [1:0]  m_idx = '0;
   logic [1:0]  p_type = '0;
   logic [1:0]  p_idx = '0;
   int          m_cnt = 0;
   logic        wr_ok;
   logic [1:0]  l_type;
   logic [1:0]  l_idx;
   int          l_lat;

   // Table as a launch on this edge would see it, and the result/latency
   // that launch must produce.
   always_comb begin
      wr_ok = tbl_we && !m_busy && (int'(tbl_addr) < NA);
      for (int j = 0; j < NA; j++) begin
         v_alias[j] = m_alias[j];
         v_valid[j] = m_valid[j];
      end
      if (wr_ok) begin
         v_alias[tbl_addr] = tbl_data;
         v_valid[tbl_addr] = tbl_valid;
      end
      l_type = 2'd0;
      l_idx  = 2'd0;
      l_lat  = 1 + NA;
      if (dest_id == my_id) begin
         l_type = 2'd1;
         l_lat  = 1;
      end else if (BC_EN && dest_id == 16'hFFFF) begin
         l_type = 2'd3;
         l_lat  = 1;
      end else begin
         for (int j = NA - 1; j >= 0; j--) begin
            if (v_valid[j] && v_alias[j] == dest_id) begin
               l_type = 2'd2;
               l_idx  = j[1:0];
               l_lat  = 2 + j;
            end
         end
      end
   end

   always @(posedge clock) begin
      if (rst) begin
         live   <= 1'b1;
         m_busy <= 1'b0;
         m_done <= 1'b0;
         m_type <= '0;
         m_idx  <= '0;
         m_cnt  <= 0;
         for (int j = 0; j < NA; j++) m_valid[j] <= 1'b0;
      end else begin
         if (wr_ok) begin
            m_alias[tbl_addr] <= tbl_data;
            m_valid[tbl_addr] <= tbl_valid;
         end
         if (!en) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_type <= '0;
            m_idx  <= '0;
            m_cnt  <= 0;
         end else if (m_busy) begin
            if (m_cnt == 1) begin
               m_busy <= 1'b0;
               m_done <= 1'b1;
               m_type <= p_type;
               m_idx  <= p_idx;
            end
            m_cnt <= m_cnt - 1;
         end else if (start) begin
            p_type <= l_type;
            p_idx  <= l_idx;
            m_cnt  <= l_lat;
            m_busy <= 1'b1;
            m_done <= 1'b0;
            m_type <= '0;
            m_idx  <= '0;
         end
      end
   end

   // Per-cycle comparison against the model
   always @(negedge clock) begin
      if (live) begin
         check("cycle busy/done/iam", {29'd0, busy, done, iam},
               {29'd0, m_busy, m_done, m_done && (m_type != 2'd0)});
         if (m_busy || m_done) begin
            check("cycle type/index", {28'd0, mtype, midx}, {28'd0, m_type, m_idx});
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Stimulus helpers (all start and end just after a falling edge)
   // ---------------------------------------------------------------------------
   task automatic write_entry(input logic [1:0] a, input logic [15:0] d, input logic v);
      tbl_we    = 1'b1;
      tbl_addr  = a;
      tbl_data  = d;
      tbl_valid = v;
      @(negedge clock);
      tbl_we = 1'b0;
      $display("txn write: addr=%0d data=%h valid=%0d", a, d, v);
   endtask

   task automatic run_match(input string name, input logic [15:0] my, input logic [15:0] d,
                            input int exp_lat, input logic [1:0] exp_t, input logic [1:0] exp_i,
                            input bit wr, input logic [1:0] wa, input logic [15:0] wd);
      int lat;
      my_id   = my;
      dest_id = d;
      start   = 1'b1;
      if (wr) begin
         tbl_we    = 1'b1;
         tbl_addr  = wa;
         tbl_data  = wd;
         tbl_valid = 1'b1;
      end
      @(negedge clock);             // edge k has sampled start
      start  = 1'b0;
      tbl_we = 1'b0;
      // Later input changes must not disturb the latched operands.
      dest_id = d ^ 16'h00F0;
      my_id   = my ^ 16'h0F00;
      lat = 0;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clock);
         if (done === 1'b1) begin
            lat = n;
            break;
         end
      end
      check({name, " latency"}, lat, exp_lat);
      check({name, " type"}, {30'd0, mtype}, {30'd0, exp_t});
      check({name, " index"}, {30'd0, midx}, {30'd0, exp_i});
      check({name, " iam"}, {31'd0, iam}, {31'd0, exp_t != 2'd0});
      $display("txn %s: my=%h dest=%h type=%0d idx=%0d iam=%0d latency=%0d",
               name, my, d, mtype, midx, iam, lat);
   endtask

   // ---------------------------------------------------------------------------
   // Directed sequence
   // ---------------------------------------------------------------------------
   initial begin
      @(negedge clock);
      rst = 1'b1;
      repeat (3) @(negedge clock);
      check("reset iam", {31'd0, iam}, 32'd0);
      check("reset type", {30'd0, mtype}, 32'd0);
      check("reset index", {30'd0, midx}, 32'd0);
      check("reset busy", {31'd0, busy}, 32'd0);
      check("reset done", {31'd0, done}, 32'd0);
      $display("txn reset: outputs iam=%0d type=%0d busy=%0d done=%0d", iam, mtype, busy, done);
      rst = 1'b0;
      en  = 1'b1;
      @(negedge clock);

      // Self hit, then held while idle in DONE
      run_match("self", 16'h0005, 16'h0005, 1, 2'b01, 2'd0, 1'b0, 2'd0, 16'h0);
      repeat (3) @(negedge clock);
      check("self held done", {31'd0, done}, 32'd1);
      check("self held type", {30'd0, mtype}, 32'd1);

      // Alias priority: lowest index wins (relaunch straight from DONE)
      write_entry(2'd1, 16'h0030, 1'b1);
      write_entry(2'd3, 16'h0030, 1'b1);
      run_match("alias prio", 16'h0005, 16'h0030, 3, 2'b10, 2'd1, 1'b0, 2'd0, 16'h0);

      // Deletion and no match
      write_entry(2'd1, 16'h0030, 1'b0);
      run_match("no match", 16'h0005, 16'h0031, 5, 2'b00, 2'd0, 1'b0, 2'd0, 16'h0);
      run_match("alias last", 16'h0005, 16'h0030, 5, 2'b10, 2'd3, 1'b0, 2'd0, 16'h0);

      // Broadcast
      if (BC_EN)
         run_match("bcast", 16'h0005, 16'hFFFF, 1, 2'b11, 2'd0, 1'b0, 2'd0, 16'h0);
      else
         run_match("bcast", 16'h0005, 16'hFFFF, 5, 2'b00, 2'd0, 1'b0, 2'd0, 16'h0);

      // Abort: en sampled low at edge k+2 during SCAN
      my_id = 16'h0005; dest_id = 16'h0031; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      @(negedge clock);
      en = 1'b0;
      @(negedge clock);
      check("abort busy", {31'd0, busy}, 32'd0);
      check("abort done", {31'd0, done}, 32'd0);
      repeat (5) @(negedge clock);
      check("abort no done", {31'd0, done}, 32'd0);
      $display("txn abort: busy=%0d done=%0d", busy, done);
      en = 1'b1;
      @(negedge clock);

      // Reset during SCAN clears outputs and table valids
      my_id = 16'h0005; dest_id = 16'h0031; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      @(negedge clock);
      rst = 1'b1;
      @(negedge clock);
      rst = 1'b0;
      check("rst scan busy", {31'd0, busy}, 32'd0);
      check("rst scan done", {31'd0, done}, 32'd0);
      check("rst scan type", {30'd0, mtype}, 32'd0);
      $display("txn reset mid-scan: busy=%0d done=%0d", busy, done);
      run_match("after rst", 16'h0005, 16'h0030, 5, 2'b00, 2'd0, 1'b0, 2'd0, 16'h0);

      // Write while busy is dropped
      write_entry(2'd0, 16'h0040, 1'b1);
      my_id = 16'h0005; dest_id = 16'h0099; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      tbl_we = 1'b1; tbl_addr = 2'd0; tbl_data = 16'h0050; tbl_valid = 1'b1;
      @(negedge clock);
      tbl_we = 1'b0;
      for (int n = 0; n < 20 && done !== 1'b1; n++) @(negedge clock);
      check("busy write done", {31'd0, done}, 32'd1);
      $display("txn busy write: dropped write attempted, done=%0d", done);
      run_match("old entry", 16'h0005, 16'h0040, 2, 2'b10, 2'd0, 1'b0, 2'd0, 16'h0);
      run_match("dropped entry", 16'h0005, 16'h0050, 5, 2'b00, 2'd0, 1'b0, 2'd0, 16'h0);

      // Write and start on the same edge
      run_match("same edge", 16'h0005, 16'h0077, 4, 2'b10, 2'd2, 1'b1, 2'd2, 16'h0077);

      repeat (2) @(negedge clock);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
